// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the launch FSM state encoding.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StBusy  = 2'd2,
    StGap   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty flags.
module sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = uart_pkg::DATA_W,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [AddrW:0]    count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [AddrW:0] FullCount = DEPTH[AddrW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]    count_q, count_d;
  logic              full_q, empty_q;
  logic              wr_ok, rd_ok;

  // A full FIFO refuses writes even when a pop happens on the same edge.
  assign wr_ok = wr_en_i && !full_q;
  assign rd_ok = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FullCount);
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the UART transmitter: buffers writes and launches one
// frame at a time, waiting for the transmitter's done pulse plus a short gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned GAP_CLKS = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_l,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_ovf_clr,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done
);

  localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  tx_state_e         state_q;
  logic [GapW-1:0]   gap_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic              overflow_q;
  logic [DATA_W-1:0] head;
  logic              launch;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i     (i_clk_sys),
    .rst_ni    (i_rst_l),
    .wr_en_i   (i_wr_en),
    .wr_data_i (i_wr_data),
    .rd_en_i   (launch),
    .rd_data_o (head),
    .count_o   (o_count),
    .full_o    (o_full),
    .empty_o   (o_empty)
  );

  // The last gap cycle may launch directly so the next start lands
  // GAP_CLKS+1 cycles after the done pulse.
  assign launch = !o_empty && !i_tx_active &&
                  ((state_q == StIdle) || ((state_q == StGap) && (gap_q == '0)));

  always_ff @(posedge i_clk_sys or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      if (launch) begin
        tx_byte_q  <= head;
        tx_start_q <= 1'b1;
        state_q    <= StStart;
      end else begin
        unique case (state_q)
          StIdle:  state_q <= StIdle;
          StStart: state_q <= StBusy;
          StBusy: begin
            if (i_tx_done) begin
              gap_q   <= GapW'(GAP_CLKS - 1);
              state_q <= StGap;
            end
          end
          StGap: begin
            if (gap_q == '0) begin
              state_q <= StIdle;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Set wins over clear when a drop and a clear coincide.
  always_ff @(posedge i_clk_sys or negedge i_rst_l) begin
    if (!i_rst_l) begin
      overflow_q <= 1'b0;
    end else if (i_wr_en && o_full) begin
      overflow_q <= 1'b1;
    end else if (i_ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small transmitter stand-in.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       full, empty, overflow, tx_start;
  logic [4:0] count;
  logic [7:0] tx_byte;

  logic tx_active = 1'b0;
  logic tx_done = 1'b0;
  logic force_active = 1'b0;
  logic stray_done = 1'b0;
  int   tx_len = 20;
  int   busy_left = 0;
  int   cyc = 0;

  logic [7:0] sent_q[$];
  int         start_q[$];
  int         done_q[$];

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(
    .DEPTH    (16),
    .GAP_CLKS (1)
  ) dut (
    .i_clk_sys   (clk),
    .i_rst_l     (rst_l),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_ovf_clr   (ovf_clr),
    .o_full      (full),
    .o_empty     (empty),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_tx_start  (tx_start),
    .o_tx_byte   (tx_byte),
    .i_tx_active (tx_active | force_active),
    .i_tx_done   (tx_done | stray_done)
  );

  // Transmitter stand-in: busy for tx_len cycles after each start, then a done pulse.
  always @(negedge clk) begin
    if (!rst_l) begin
      tx_active = 1'b0;
      tx_done   = 1'b0;
      busy_left = 0;
    end else begin
      tx_done = 1'b0;
      if (tx_active) begin
        if (busy_left <= 1) begin
          tx_active = 1'b0;
          tx_done   = 1'b1;
          done_q.push_back(cyc);
        end else begin
          busy_left--;
        end
      end
      if (tx_start) begin
        sent_q.push_back(tx_byte);
        start_q.push_back(cyc);
        tx_active = 1'b1;
        busy_left = tx_len;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int base, dbase, peak;

    // Reset and idle
    repeat (5) tick();
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_start", tx_start, 0);
    check("rst_byte", tx_byte, 8'h00);
    rst_l = 1'b1;
    repeat (100) tick();
    check("idle_no_start", sent_q.size(), 0);
    check("idle_empty", empty, 1);

    // Single byte: start visible one edge after the accepting edge
    base = sent_q.size();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    check("single_count1", count, 1);
    check("single_notempty", empty, 0);
    check("single_nostart_e0", tx_start, 0);
    tick();
    check("single_start_e1", tx_start, 1);
    check("single_byte", tx_byte, 8'hA5);
    check("single_empty", empty, 1);
    check("single_count0", count, 0);
    tick();
    check("single_start_low", tx_start, 0);
    check("single_byte_hold", tx_byte, 8'hA5);
    repeat (40) tick();
    check("single_nsent", sent_q.size(), base + 1);
    check("single_sent", sent_q[base], 8'hA5);

    // Burst 01..05 with done-to-start spacing
    base = sent_q.size();
    dbase = done_q.size();
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    check("burst_peak", peak, 4);
    repeat (150) tick();
    check("burst_nsent", sent_q.size(), base + 5);
    for (int i = 0; i < 5; i++) check("burst_order", sent_q[base + i], i + 1);
    for (int i = 1; i < 5; i++)
      check("burst_gap", start_q[base + i] - done_q[dbase + i - 1], 2);

    // Full / overflow with the transmitter held busy
    base = sent_q.size();
    force_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    check("full_flag", full, 1);
    check("full_count", count, 16);
    check("full_no_ovf", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    ovf_clr = 1'b0; wr_en = 1'b0;
    check("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr2", overflow, 0);
    // Pop and write to a full FIFO on the same edge: write is dropped
    force_active = 1'b0; wr_en = 1'b1; wr_data = 8'hEF;
    tick();
    wr_en = 1'b0;
    check("fullpop_count", count, 15);
    check("fullpop_ovf", overflow, 1);
    check("fullpop_notfull", full, 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    repeat (400) tick();
    check("full_nsent", sent_q.size(), base + 16);
    for (int i = 0; i < 16; i++) check("full_order", sent_q[base + i], 8'h10 + i);

    // Wrap-around while draining
    base = sent_q.size();
    tx_len = 4;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      wr_en = 1'b0;
      repeat (4) tick();
    end
    repeat (60) tick();
    check("wrap_nsent", sent_q.size(), base + 40);
    for (int i = 0; i < 40; i++) check("wrap_order", sent_q[base + i], i);
    check("wrap_no_ovf", overflow, 0);
    check("wrap_empty", empty, 1);

    // Reset mid-frame with three bytes queued
    tx_len = 50;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h61 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (3) tick();
    check("mid_queued", count, 3);
    base = sent_q.size();
    rst_l = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_byte", tx_byte, 8'h00);
    repeat (3) tick();
    rst_l = 1'b1;
    repeat (100) tick();
    check("mid_no_start", sent_q.size(), base);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    tick();
    check("post_rst_start", tx_start, 1);
    check("post_rst_byte", tx_byte, 8'h3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
